riscv_wb: RTL and testbench
===========================

Name: riscv_wb

Overview:
- Write-back stage directly downstream of the EX-stage functional units (ALU, multiplier, divider) and the data-memory load path.
- Collects one result per cycle, tracks an outstanding load, and drives the single register-file write port.
- Generates wb_stall back into EX (ORed into ex_stall by the core) while a load is outstanding.

Parameters:
- XLEN, 32, datapath width (32 or 64)
- LOAD_TIMEOUT, 15, max cycles waiting for dmem_ack before abandoning the load; 4-bit counter

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- ex_rd  in  5  destination register for any unit result presented this cycle
- alu_bubble  in  1  0 = alu_r valid
- alu_r  in  XLEN  ALU result
- mul_bubble  in  1  0 = mul_r valid
- mul_r  in  XLEN  multiplier result
- div_bubble  in  1  0 = div_r valid
- div_r  in  XLEN  divider result
- ld_req  in  1  load issued to dmem this cycle
- ld_rd  in  5  load destination register
- ld_func3  in  3  load type (LB/LH/LW/LBU/LHU, plus LD/LWU for XLEN=64)
- ld_addr  in  3  low address bits of the load
- dmem_ack  in  1  load data valid
- dmem_rdata  in  XLEN  load data
- wb_we  out  1  register-file write enable
- wb_dst  out  5  register-file write address
- wb_r  out  XLEN  register-file write data
- wb_stall  out  1  stall request to EX
- wb_load_err  out  1  one-cycle pulse: load timed out
- wb_collide  out  1  sticky: more than one unit valid in the same cycle

Behaviour:
- Reset: wb_we=0, wb_dst=0, wb_r=0, wb_stall=0, wb_load_err=0, wb_collide=0. FSM goes to ST_IDLE, cnt=0, pending buffer empty. Reset mid-load abandons the load with no write.
- All outputs are registered. Result is presented one cycle after the source.
- Unit select: priority MUL > DIV > ALU. If more than one bubble=0 in the same cycle, the highest-priority unit is written, the others are dropped, and wb_collide is set until reset.
- rd==0: the write is suppressed (wb_we=0). wb_dst and wb_r still update.
- FSM ST_IDLE:
  - ld_req=1: capture ld_rd/ld_func3/ld_addr, cnt<=0, wb_stall<=1, go to ST_LOAD.
  - A unit result in the same cycle as ld_req is written normally, in that cycle's registered output.
- FSM ST_LOAD:
  - dmem_ack=1: write the formatted load data to the captured rd (wb_we=1 if rd!=0), wb_stall<=0, go to ST_IDLE.
  - else if cnt==LOAD_TIMEOUT: pulse wb_load_err, no write, wb_stall<=0, go to ST_IDLE.
  - else cnt<=cnt+1.
  - ld_req while in ST_LOAD is ignored (EX is stalled).
- Pending buffer (one entry):
  - A unit result arriving while in ST_LOAD (an in-flight multicycle mul/div completing) is held in the buffer.
  - It is written the cycle after the load write or timeout.
  - If the buffer is full and another result arrives, the new result overwrites it and wb_collide is set.
  - While the buffer drains, a new unit result in the same cycle is written first and the buffer drains next cycle; wb_stall stays high for that cycle.
- wb_we is deasserted in every cycle with no write.

Optional Feature:
- Macro RISCV_WB_LOAD_ALIGN_EN.
- Defined: load data is byte-lane shifted by ld_addr and sign- or zero-extended per ld_func3. LB/LH/LW sign-extend; LBU/LHU/LWU zero-extend; LD passes through.
- Undefined: dmem_rdata is written unmodified; ld_addr and ld_func3 are ignored, and alignment is done in the LSU.

Decomposition:
- Shared package riscv_pkg:
  - the load func3 encodings (LB, LH, LW, LD, LBU, LHU, LWU)
  - the wb state enum ST_IDLE/ST_LOAD
- Sub-module riscv_wb_ldfmt: combinational load alignment/extension, instantiated only under RISCV_WB_LOAD_ALIGN_EN.

Test Plan:
- alu_bubble=0, alu_r=0x1234, ex_rd=5 -> next cycle wb_we=1, wb_dst=5, wb_r=0x1234.
- mul_r=0xA, alu_r=0xB both valid, ex_rd=3 -> wb_r=0xA, wb_collide=1 and remains 1.
- ld_req with rd=7, LB, ld_addr=1, dmem_rdata=0x0000_8000, ack 3 cycles later -> wb_stall high 3 cycles, then wb_r=0xFFFF_FF80, wb_dst=7 (align enabled).
- ld_req, no ack for 16 cycles (LOAD_TIMEOUT=15) -> wb_load_err pulse, wb_stall falls, no write.
- During ST_LOAD, div_r=0x55, ex_rd=9; ack on the next cycle with rd=4 -> rd 4 written, then rd 9=0x55 the following cycle.
- alu result with ex_rd=0 -> wb_we=0; assert rst during ST_LOAD -> all outputs 0, no write after release.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the write-back stage: load func3 encodings and FSM states.
package riscv_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } wb_state_e;

endpackage

// File: rtl/riscv_wb_if.sv
// Bundle of EX-unit results, load tracking/dmem response and register-file write outputs.
interface riscv_wb_if #(parameter int XLEN = 32) ();

  logic [4:0]      ex_rd;
  logic            alu_bubble;
  logic [XLEN-1:0] alu_r;
  logic            mul_bubble;
  logic [XLEN-1:0] mul_r;
  logic            div_bubble;
  logic [XLEN-1:0] div_r;
  logic            ld_req;
  logic [4:0]      ld_rd;
  logic [2:0]      ld_func3;
  logic [2:0]      ld_addr;
  logic            dmem_ack;
  logic [XLEN-1:0] dmem_rdata;
  logic            wb_we;
  logic [4:0]      wb_dst;
  logic [XLEN-1:0] wb_r;
  logic            wb_stall;
  logic            wb_load_err;
  logic            wb_collide;

  modport slave (
    input  ex_rd, alu_bubble, alu_r, mul_bubble, mul_r, div_bubble, div_r,
    input  ld_req, ld_rd, ld_func3, ld_addr, dmem_ack, dmem_rdata,
    output wb_we, wb_dst, wb_r, wb_stall, wb_load_err, wb_collide
  );

  modport master (
    output ex_rd, alu_bubble, alu_r, mul_bubble, mul_r, div_bubble, div_r,
    output ld_req, ld_rd, ld_func3, ld_addr, dmem_ack, dmem_rdata,
    input  wb_we, wb_dst, wb_r, wb_stall, wb_load_err, wb_collide
  );

endinterface

// File: rtl/riscv_wb_ldfmt.sv
// Combinational load formatter: byte-lane shift by address, then sign/zero extension.
// Used by riscv_wb only when RISCV_WB_LOAD_ALIGN_EN is defined.
module riscv_wb_ldfmt
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      func3,
  input  logic [2:0]      addr,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] data
);

  logic [5:0]      sh;
  logic [XLEN-1:0] s;

  // Only the lane bits that exist in an XLEN-wide word take part in the shift.
  always_comb begin
    sh = {addr, 3'b000} & ((XLEN == 64) ? 6'h38 : 6'h18);
    s  = rdata >> sh;
    case (func3)
      F3_LB:   data = XLEN'($signed(s[7:0]));
      F3_LH:   data = XLEN'($signed(s[15:0]));
      F3_LW:   data = XLEN'($signed(s[31:0]));
      F3_LBU:  data = XLEN'(s[7:0]);
      F3_LHU:  data = XLEN'(s[15:0]);
      F3_LWU:  data = XLEN'(s[31:0]);
      default: data = s;
    endcase
  end

endmodule

// File: rtl/riscv_wb.sv
// Write-back stage: unit result select, outstanding-load FSM with timeout, one-entry pending buffer.
// Optional RISCV_WB_LOAD_ALIGN_EN formats load data here instead of in the LSU.
module riscv_wb
  import riscv_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int LOAD_TIMEOUT = 15
) (
  input logic       clk,
  input logic       rst,
  riscv_wb_if.slave bus
);

  wb_state_e       state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [4:0]      ld_rd_q, ld_rd_d;
  logic            pend_valid_q, pend_valid_d;
  logic [4:0]      pend_rd_q, pend_rd_d;
  logic [XLEN-1:0] pend_r_q, pend_r_d;
  logic            wb_we_q, wb_we_d;
  logic [4:0]      wb_dst_q, wb_dst_d;
  logic [XLEN-1:0] wb_r_q, wb_r_d;
  logic            wb_stall_q, wb_stall_d;
  logic            wb_load_err_q, wb_load_err_d;
  logic            wb_collide_q, wb_collide_d;

  logic            mul_v, div_v, alu_v, unit_v, multi;
  logic [XLEN-1:0] unit_r, ld_data;

`ifdef RISCV_WB_LOAD_ALIGN_EN
  logic [2:0] ld_func3_q, ld_func3_d;
  logic [2:0] ld_addr_q, ld_addr_d;

  riscv_wb_ldfmt #(.XLEN(XLEN)) u_ldfmt (
    .func3 (ld_func3_q),
    .addr  (ld_addr_q),
    .rdata (bus.dmem_rdata),
    .data  (ld_data)
  );
`else
  assign ld_data = bus.dmem_rdata;
`endif

  always_comb begin
    mul_v  = ~bus.mul_bubble;
    div_v  = ~bus.div_bubble;
    alu_v  = ~bus.alu_bubble;
    unit_v = mul_v | div_v | alu_v;
    multi  = (mul_v & div_v) | (mul_v & alu_v) | (div_v & alu_v);
    unit_r = mul_v ? bus.mul_r : (div_v ? bus.div_r : bus.alu_r);
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ld_rd_d       = ld_rd_q;
    pend_valid_d  = pend_valid_q;
    pend_rd_d     = pend_rd_q;
    pend_r_d      = pend_r_q;
    wb_we_d       = 1'b0;
    wb_dst_d      = wb_dst_q;
    wb_r_d        = wb_r_q;
    wb_stall_d    = wb_stall_q;
    wb_load_err_d = 1'b0;
    wb_collide_d  = wb_collide_q | multi;
`ifdef RISCV_WB_LOAD_ALIGN_EN
    ld_func3_d    = ld_func3_q;
    ld_addr_d     = ld_addr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // A fresh unit result wins the write port; a held result waits one more cycle.
        if (unit_v) begin
          wb_we_d  = (bus.ex_rd != 5'd0);
          wb_dst_d = bus.ex_rd;
          wb_r_d   = unit_r;
        end else if (pend_valid_q) begin
          wb_we_d      = (pend_rd_q != 5'd0);
          wb_dst_d     = pend_rd_q;
          wb_r_d       = pend_r_q;
          pend_valid_d = 1'b0;
        end
        wb_stall_d = bus.ld_req | (pend_valid_q & unit_v);
        if (bus.ld_req) begin
          state_d = ST_LOAD;
          cnt_d   = 4'd0;
          ld_rd_d = bus.ld_rd;
`ifdef RISCV_WB_LOAD_ALIGN_EN
          ld_func3_d = bus.ld_func3;
          ld_addr_d  = bus.ld_addr;
`endif
        end
      end
      ST_LOAD: begin
        if (unit_v) begin
          pend_valid_d = 1'b1;
          pend_rd_d    = bus.ex_rd;
          pend_r_d     = unit_r;
          if (pend_valid_q) wb_collide_d = 1'b1;
        end
        if (bus.dmem_ack) begin
          wb_we_d    = (ld_rd_q != 5'd0);
          wb_dst_d   = ld_rd_q;
          wb_r_d     = ld_data;
          wb_stall_d = 1'b0;
          state_d    = ST_IDLE;
        end else if (cnt_q == 4'(LOAD_TIMEOUT)) begin
          wb_load_err_d = 1'b1;
          wb_stall_d    = 1'b0;
          state_d       = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 4'd0;
      ld_rd_q       <= 5'd0;
      pend_valid_q  <= 1'b0;
      pend_rd_q     <= 5'd0;
      pend_r_q      <= '0;
      wb_we_q       <= 1'b0;
      wb_dst_q      <= 5'd0;
      wb_r_q        <= '0;
      wb_stall_q    <= 1'b0;
      wb_load_err_q <= 1'b0;
      wb_collide_q  <= 1'b0;
`ifdef RISCV_WB_LOAD_ALIGN_EN
      ld_func3_q    <= 3'd0;
      ld_addr_q     <= 3'd0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ld_rd_q       <= ld_rd_d;
      pend_valid_q  <= pend_valid_d;
      pend_rd_q     <= pend_rd_d;
      pend_r_q      <= pend_r_d;
      wb_we_q       <= wb_we_d;
      wb_dst_q      <= wb_dst_d;
      wb_r_q        <= wb_r_d;
      wb_stall_q    <= wb_stall_d;
      wb_load_err_q <= wb_load_err_d;
      wb_collide_q  <= wb_collide_d;
`ifdef RISCV_WB_LOAD_ALIGN_EN
      ld_func3_q    <= ld_func3_d;
      ld_addr_q     <= ld_addr_d;
`endif
    end
  end

  assign bus.wb_we       = wb_we_q;
  assign bus.wb_dst      = wb_dst_q;
  assign bus.wb_r        = wb_r_q;
  assign bus.wb_stall    = wb_stall_q;
  assign bus.wb_load_err = wb_load_err_q;
  assign bus.wb_collide  = wb_collide_q;

endmodule

// File: tb/tb_riscv_wb.sv
// Testbench for riscv_wb: directed scenarios plus randomized traffic, all checked every cycle
// against a transaction-level model of the write-back rules.
module tb_riscv_wb;
  import riscv_pkg::*;

  localparam int XLEN         = 32;
  localparam int LOAD_TIMEOUT = 15;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] r;
  } pend_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  riscv_wb_if #(.XLEN(XLEN)) bus ();

  riscv_wb #(.XLEN(XLEN), .LOAD_TIMEOUT(LOAD_TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model of the expected registered outputs
  logic        m_we = 1'b0;
  logic [4:0]  m_dst = 5'd0;
  logic [31:0] m_r = 32'd0;
  logic        m_stall = 1'b0;
  logic        m_err = 1'b0;
  logic        m_collide = 1'b0;
  bit          loading = 1'b0;
  int          waited = 0;
  logic [4:0]  l_rd = 5'd0;
  logic [2:0]  l_f3 = 3'd0;
  logic [2:0]  l_addr = 3'd0;
  pend_t       pend[$];

  function automatic logic [31:0] fmtLoad(logic [2:0] f3, logic [2:0] a, logic [31:0] d);
`ifdef RISCV_WB_LOAD_ALIGN_EN
    logic [31:0] s;
    s = d >> (8 * (int'(a) % 4));
    case (f3)
      F3_LB:   return 32'($signed(s[7:0]));
      F3_LH:   return 32'($signed(s[15:0]));
      F3_LBU:  return s & 32'hFF;
      F3_LHU:  return s & 32'hFFFF;
      default: return s;
    endcase
`else
    if (f3 == 3'd7 && a == 3'd7) return d;
    return d;
`endif
  endfunction

  task automatic modelWrite(logic [4:0] rd, logic [31:0] r);
    m_we  = (rd != 5'd0);
    m_dst = rd;
    m_r   = r;
  endtask

  task automatic modelStep();
    int          nv;
    logic [31:0] r;
    pend_t       e;
    nv = 0;
    if (!bus.mul_bubble) nv++;
    if (!bus.div_bubble) nv++;
    if (!bus.alu_bubble) nv++;
    r = !bus.mul_bubble ? bus.mul_r : (!bus.div_bubble ? bus.div_r : bus.alu_r);
    m_we  = 1'b0;
    m_err = 1'b0;
    if (nv > 1) m_collide = 1'b1;
    if (!loading) begin
      if (nv > 0) modelWrite(bus.ex_rd, r);
      else if (pend.size() > 0) begin
        modelWrite(pend[0].rd, pend[0].r);
        void'(pend.pop_front());
      end
      m_stall = bus.ld_req || (pend.size() > 0);
      if (bus.ld_req) begin
        loading = 1'b1;
        waited  = 0;
        l_rd    = bus.ld_rd;
        l_f3    = bus.ld_func3;
        l_addr  = bus.ld_addr;
      end
    end else begin
      if (nv > 0) begin
        if (pend.size() > 0) m_collide = 1'b1;
        pend.delete();
        e.rd = bus.ex_rd;
        e.r  = r;
        pend.push_back(e);
      end
      if (bus.dmem_ack) begin
        modelWrite(l_rd, fmtLoad(l_f3, l_addr, bus.dmem_rdata));
        loading = 1'b0;
        m_stall = 1'b0;
      end else if (waited == LOAD_TIMEOUT) begin
        m_err   = 1'b1;
        loading = 1'b0;
        m_stall = 1'b0;
      end else begin
        waited++;
      end
    end
  endtask

  // Model advances on the same edge the DUT registers its outputs
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_we = 1'b0; m_dst = 5'd0; m_r = 32'd0; m_stall = 1'b0; m_err = 1'b0; m_collide = 1'b0;
      loading = 1'b0; waited = 0;
      pend.delete();
    end else begin
      modelStep();
    end
  end

  task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic checkOutput();
    cmp("wb_we", 32'(bus.wb_we), 32'(m_we));
    cmp("wb_dst", 32'(bus.wb_dst), 32'(m_dst));
    cmp("wb_r", bus.wb_r, m_r);
    cmp("wb_stall", 32'(bus.wb_stall), 32'(m_stall));
    cmp("wb_load_err", 32'(bus.wb_load_err), 32'(m_err));
    cmp("wb_collide", 32'(bus.wb_collide), 32'(m_collide));
  endtask

  always @(negedge clk) begin
    if (!rst) checkOutput();
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(logic mb, logic db, logic ab, logic [4:0] rd,
                               logic [31:0] mr, logic [31:0] dr, logic [31:0] ar);
    bus.mul_bubble = mb; bus.div_bubble = db; bus.alu_bubble = ab;
    bus.ex_rd = rd; bus.mul_r = mr; bus.div_r = dr; bus.alu_r = ar;
  endtask

  task automatic idleInputs();
    applyStimulus(1'b1, 1'b1, 1'b1, 5'd0, 32'd0, 32'd0, 32'd0);
    bus.ld_req = 1'b0; bus.ld_rd = 5'd0; bus.ld_func3 = 3'd0; bus.ld_addr = 3'd0;
    bus.dmem_ack = 1'b0; bus.dmem_rdata = 32'd0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic startLoad(logic [4:0] rd, logic [2:0] f3, logic [2:0] a);
    bus.ld_req = 1'b1; bus.ld_rd = rd; bus.ld_func3 = f3; bus.ld_addr = a;
    cyc();
    bus.ld_req = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_lb;
    int          ack_pct;
    idleInputs();
    cyc();
    cmp("reset_we", 32'(bus.wb_we), 32'd0);
    cmp("reset_r", bus.wb_r, 32'd0);
    cmp("reset_stall", 32'(bus.wb_stall), 32'd0);
    cmp("reset_collide", 32'(bus.wb_collide), 32'd0);
    cyc();
    rst = 1'b0;

    $display("[TB] single ALU write");
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd5, 32'd0, 32'd0, 32'h1234);
    cyc();
    idleInputs();
    cmp("alu_we", 32'(bus.wb_we), 32'd1);
    cmp("alu_dst", 32'(bus.wb_dst), 32'd5);
    cmp("alu_r", bus.wb_r, 32'h1234);
    cyc();
    cmp("alu_we_drop", 32'(bus.wb_we), 32'd0);

    $display("[TB] MUL and ALU collide");
    applyStimulus(1'b0, 1'b1, 1'b0, 5'd3, 32'hA, 32'd0, 32'hB);
    cyc();
    idleInputs();
    cmp("collide_r", bus.wb_r, 32'hA);
    cmp("collide_flag", 32'(bus.wb_collide), 32'd1);
    cyc();
    cyc();
    cmp("collide_sticky", 32'(bus.wb_collide), 32'd1);
    doReset();

    $display("[TB] LB load, ack after 3 cycles");
    bus.dmem_rdata = 32'h0000_8000;
    startLoad(5'd7, F3_LB, 3'd1);
    cmp("ld_stall1", 32'(bus.wb_stall), 32'd1);
    cyc();
    cmp("ld_stall2", 32'(bus.wb_stall), 32'd1);
    cyc();
    cmp("ld_stall3", 32'(bus.wb_stall), 32'd1);
    bus.dmem_ack = 1'b1;
    cyc();
    bus.dmem_ack = 1'b0;
`ifdef RISCV_WB_LOAD_ALIGN_EN
    exp_lb = 32'hFFFF_FF80;
`else
    exp_lb = 32'h0000_8000;
`endif
    cmp("ld_stall_fall", 32'(bus.wb_stall), 32'd0);
    cmp("ld_we", 32'(bus.wb_we), 32'd1);
    cmp("ld_dst", 32'(bus.wb_dst), 32'd7);
    cmp("ld_r", bus.wb_r, exp_lb);

    $display("[TB] load timeout");
    startLoad(5'd8, F3_LW, 3'd0);
    for (int i = 0; i < LOAD_TIMEOUT; i++) begin
      cyc();
      cmp("to_err_early", 32'(bus.wb_load_err), 32'd0);
    end
    cmp("to_stall_held", 32'(bus.wb_stall), 32'd1);
    cyc();
    cmp("to_err", 32'(bus.wb_load_err), 32'd1);
    cmp("to_stall", 32'(bus.wb_stall), 32'd0);
    cmp("to_we", 32'(bus.wb_we), 32'd0);
    cyc();
    cmp("to_err_pulse", 32'(bus.wb_load_err), 32'd0);

    $display("[TB] DIV result held behind load");
    bus.dmem_rdata = 32'h1234_5678;
    startLoad(5'd4, F3_LW, 3'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 5'd9, 32'd0, 32'h55, 32'd0);
    cyc();
    applyStimulus(1'b1, 1'b1, 1'b1, 5'd0, 32'd0, 32'd0, 32'd0);
    bus.dmem_ack = 1'b1;
    cyc();
    bus.dmem_ack = 1'b0;
    cmp("pend_ld_dst", 32'(bus.wb_dst), 32'd4);
    cmp("pend_ld_r", bus.wb_r, 32'h1234_5678);
    cyc();
    cmp("pend_we", 32'(bus.wb_we), 32'd1);
    cmp("pend_dst", 32'(bus.wb_dst), 32'd9);
    cmp("pend_r", bus.wb_r, 32'h55);

    $display("[TB] rd=0 suppression and reset during load");
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 32'd0, 32'h77);
    cyc();
    idleInputs();
    cmp("rd0_we", 32'(bus.wb_we), 32'd0);
    cmp("rd0_r", bus.wb_r, 32'h77);
    startLoad(5'd6, F3_LW, 3'd0);
    cyc();
    rst = 1'b1;
    #1;
    cmp("rst_stall", 32'(bus.wb_stall), 32'd0);
    cmp("rst_dst", 32'(bus.wb_dst), 32'd0);
    cmp("rst_r", bus.wb_r, 32'd0);
    cyc();
    rst = 1'b0;
    bus.dmem_ack = 1'b1;
    bus.dmem_rdata = 32'hDEAD_BEEF;
    cyc();
    idleInputs();
    cmp("rst_abandon_we", 32'(bus.wb_we), 32'd0);

    $display("[TB] randomized traffic");
    ack_pct = 30;
    for (int i = 0; i < 4000; i++) begin
      if (i % 250 == 0) ack_pct = (ack_pct == 30) ? 3 : 30;
      if (i % 1000 == 999) doReset();
      applyStimulus(1'($urandom_range(0, 99) >= 12), 1'($urandom_range(0, 99) >= 12),
                    1'($urandom_range(0, 99) >= 25), 5'($urandom_range(0, 31)),
                    $urandom, $urandom, $urandom);
      bus.ld_req     = ($urandom_range(0, 7) == 0);
      bus.ld_rd      = 5'($urandom_range(0, 31));
      bus.ld_func3   = 3'($urandom_range(0, 7));
      bus.ld_addr    = 3'($urandom_range(0, 7));
      bus.dmem_ack   = ($urandom_range(0, 99) < ack_pct);
      bus.dmem_rdata = $urandom;
      cyc();
    end
    idleInputs();
    cyc();
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
